// File: rtl/led_blink_multi_pkg.sv
// Shared mode encodings and field widths
// for the multi-channel LED pattern generator.
package led_blink_multi_pkg;

  localparam int MODE_W  = 2;
  localparam int BURST_W = 8;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_t;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_blink_multi_channel.sv
// One LED channel: mode, half-period counter,
// burst pulse budget and registered led/busy.
module led_blink_multi_channel
  import led_blink_multi_pkg::*;
#(
  parameter int CNT_WIDTH = 26,
  parameter logic [CNT_WIDTH-1:0] DEFAULT_PERIOD =
    CNT_WIDTH'(50000000),
  parameter logic [CNT_WIDTH-1:0] INIT = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 load,
  input  logic [MODE_W-1:0]    cfg_mode,
  input  logic [CNT_WIDTH-1:0] cfg_period,
  input  logic [BURST_W-1:0]   cfg_count,
  output logic                 led,
  output logic                 busy
);

  mode_t                mode, mode_n;
  logic [CNT_WIDTH-1:0] period, period_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;
  logic [BURST_W-1:0]   rem, rem_n;
  logic                 led_n, busy_n;
  logic                 wrap;
  mode_t                new_mode;

  assign wrap = cnt == period - CNT_WIDTH'(1);
  assign new_mode = mode_t'(cfg_mode);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode   <= MODE_BLINK;
      period <= DEFAULT_PERIOD;
      cnt    <= INIT;
      rem    <= '0;
      led    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      mode   <= mode_n;
      period <= period_n;
      cnt    <= cnt_n;
      rem    <= rem_n;
      led    <= led_n;
      busy   <= busy_n;
    end
  end

  always_comb begin
    mode_n   = mode;
    period_n = period;
    cnt_n    = cnt;
    rem_n    = rem;
    led_n    = led;
    busy_n   = busy;
    if (load) begin
      cnt_n    = '0;
      period_n = (cfg_period == '0) ?
                 CNT_WIDTH'(1) : cfg_period;
      rem_n    = cfg_count;
      mode_n   = new_mode;
      led_n    = new_mode == MODE_ON;
      busy_n   = 1'b0;
      if (new_mode == MODE_BURST) begin
        busy_n = cfg_count != '0;
        if (cfg_count == '0)
          mode_n = MODE_OFF;
      end
    end else begin
      unique case (mode)
        MODE_OFF: begin
          cnt_n = '0;
          led_n = 1'b0;
        end
        MODE_ON: begin
          cnt_n = '0;
          led_n = 1'b1;
        end
        MODE_BLINK,
        MODE_BURST: begin
          if (tick) begin
            if (wrap) begin
              cnt_n = '0;
              led_n = ~led;
              // a falling edge spends one burst pulse
              if (mode == MODE_BURST && led) begin
                rem_n = rem - BURST_W'(1);
                if (rem == BURST_W'(1)) begin
                  mode_n = MODE_OFF;
                  busy_n = 1'b0;
                end
              end
            end else begin
              cnt_n = cnt + CNT_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/led_blink_multi.sv
// Multi-channel LED pattern generator: prescaler,
// config handshake and per-channel pattern engines.
module led_blink_multi
  import led_blink_multi_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 26,
  parameter int TICK_DIV  = 1,
  parameter logic [CNT_WIDTH-1:0] DEFAULT_PERIOD =
    CNT_WIDTH'(50000000),
  parameter logic [CNT_WIDTH-1:0] INIT = '0,
  localparam int CH_W = ch_w(CHANNELS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [MODE_W-1:0]    cfg_mode,
  input  logic [CNT_WIDTH-1:0] cfg_period,
  input  logic [BURST_W-1:0]   cfg_count,
  output logic [CHANNELS-1:0]  led,
  output logic [CHANNELS-1:0]  busy
);

  localparam int PW = (TICK_DIV > 1) ?
                      $clog2(TICK_DIV) : 1;

  logic                 tick;
  logic                 acc;
  logic                 pend;
  logic [CH_W-1:0]      pend_ch;
  logic [MODE_W-1:0]    pend_mode;
  logic [CNT_WIDTH-1:0] pend_period;
  logic [BURST_W-1:0]   pend_count;

  generate
    if (TICK_DIV <= 1) begin : g_nodiv
      assign tick = 1'b1;
    end else begin : g_div
      logic [PW-1:0] presc;
      assign tick = presc == PW'(TICK_DIV - 1);
      always_ff @(posedge clk) begin
        if (!rst_n)
          presc <= '0;
        else if (tick)
          presc <= '0;
        else
          presc <= presc + PW'(1);
      end
    end
  endgenerate

  assign acc = cfg_valid && cfg_ready;

  // accepted fields are applied one edge later
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_ready   <= 1'b1;
      pend        <= 1'b0;
      pend_ch     <= '0;
      pend_mode   <= '0;
      pend_period <= '0;
      pend_count  <= '0;
    end else begin
      cfg_ready <= !acc;
      pend      <= acc;
      if (acc) begin
        pend_ch     <= cfg_ch;
        pend_mode   <= cfg_mode;
        pend_period <= cfg_period;
        pend_count  <= cfg_count;
      end
    end
  end

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic load;
      assign load = pend && (pend_ch == CH_W'(i));
      led_blink_multi_channel #(
        .CNT_WIDTH      (CNT_WIDTH),
        .DEFAULT_PERIOD (DEFAULT_PERIOD),
        .INIT           (INIT)
      ) u_ch (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .load       (load),
        .cfg_mode   (pend_mode),
        .cfg_period (pend_period),
        .cfg_count  (pend_count),
        .led        (led[i]),
        .busy       (busy[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_led_blink_multi.sv
// Randomized bench: time-based reference model
// feeds a queue, a negedge monitor checks it.
module tb_led_blink_multi;

  localparam int NCH = 3;
  localparam int CW  = 8;
  localparam int DIV = 2;
  localparam int DEF = 20;
  localparam int INI = 12;

  logic          clk;
  logic          rst_n;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_ch;
  logic [1:0]    cfg_mode;
  logic [CW-1:0] cfg_period;
  logic [7:0]    cfg_count;
  logic [NCH-1:0] led;
  logic [NCH-1:0] busy;

  led_blink_multi #(
    .CHANNELS       (NCH),
    .CNT_WIDTH      (CW),
    .TICK_DIV       (DIV),
    .DEFAULT_PERIOD (CW'(DEF)),
    .INIT           (CW'(INI))
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .cfg_count  (cfg_count),
    .led        (led),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit rdy;
    bit [NCH-1:0] led;
    bit [NCH-1:0] busy;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int passed = 0;
  int cyc = 0;

  // channel state: mode, half-period, phase offset,
  // tick count at last apply, burst pulse budget
  int m_mode[NCH];
  int m_p[NCH];
  int m_off[NCH];
  int m_t0[NCH];
  int m_cnt[NCH];
  int e;
  bit m_rdy;
  bit pv;
  int p_ch, p_mode, p_per, p_cnt;

  initial begin
    e = 0;
    m_rdy = 1'b1;
    pv = 1'b0;
    forever begin
      exp_t x;
      int tk;
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        e = 0;
        pv = 1'b0;
        m_rdy = 1'b1;
        for (int c = 0; c < NCH; c++) begin
          m_mode[c] = 2;
          m_p[c] = DEF;
          m_off[c] = INI;
          m_t0[c] = 0;
          m_cnt[c] = 0;
        end
      end else begin
        e++;
        if (pv && p_ch < NCH) begin
          m_mode[p_ch] = (p_mode == 3 && p_cnt == 0) ?
                         0 : p_mode;
          m_p[p_ch] = (p_per == 0) ? 1 : p_per;
          m_off[p_ch] = 0;
          m_t0[p_ch] = e / DIV;
          m_cnt[p_ch] = p_cnt;
        end
        pv = cfg_valid && m_rdy;
        m_rdy = !pv;
        if (pv) begin
          p_ch = int'(cfg_ch);
          p_mode = int'(cfg_mode);
          p_per = int'(cfg_period);
          p_cnt = int'(cfg_count);
        end
      end
      tk = e / DIV;
      x.cyc = cyc;
      x.rdy = m_rdy;
      for (int c = 0; c < NCH; c++) begin
        int k;
        k = (m_off[c] + tk - m_t0[c]) / m_p[c];
        x.led[c] = 1'b0;
        x.busy[c] = 1'b0;
        case (m_mode[c])
          1: x.led[c] = 1'b1;
          2: x.led[c] = k[0];
          3: if (k < 2 * m_cnt[c]) begin
               x.led[c] = k[0];
               x.busy[c] = 1'b1;
             end
          default: ;
        endcase
      end
      sbq.push_back(x);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      checks++;
      if (sbq.size() == 0) begin
        $display("FAIL sb_empty: no expected entry");
      end else begin
        exp_t x;
        x = sbq.pop_front();
        if (cfg_ready === x.rdy &&
            led === x.led && busy === x.busy)
          passed++;
        else
          $display("FAIL cyc%0d: got rdy=%b led=%b busy=%b exp rdy=%b led=%b busy=%b",
                   x.cyc, cfg_ready, led, busy,
                   x.rdy, x.led, x.busy);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch = '0;
    cfg_mode = '0;
    cfg_period = '0;
    cfg_count = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      rst_n = ($urandom % 500) != 0;
      cfg_valid = ($urandom % 4) == 0;
      cfg_ch = 2'($urandom % 4);
      cfg_mode = 2'($urandom % 4);
      cfg_period = CW'($urandom % 6);
      cfg_count = 8'($urandom % 4);
    end
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
